// File: rtl/alu_ctrl_if.sv
// Command, response and ALU-side signals of alu_ctrl bundled as one interface.
// The slave modport is the controller's view; master is the environment's view.
interface alu_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [7:0] A;
  logic [7:0] B;
  logic [3:0] alu_sel;
  logic [7:0] alu_out;
  logic       c_out;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_carry;
  logic       rsp_zero;
  logic       rsp_err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_out, c_out, rsp_ready,
    output cmd_ready, A, B, alu_sel, rsp_valid, rsp_data, rsp_carry, rsp_zero, rsp_err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, alu_out, c_out, rsp_ready,
    input  cmd_ready, A, B, alu_sel, rsp_valid, rsp_data, rsp_carry, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_ctrl.sv
// Sequences one command at a time through an external ALU: latch operands,
// wait EXEC_CYCLES, capture the result and hold it until the consumer takes it.
module alu_ctrl #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  alu_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);
  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_DIV   = 4'b0011;

  state_t     state_q, state_d;
  logic [3:0] cnt_q;
  logic [7:0] a_q, b_q;
  logic [3:0] sel_q;
  logic [7:0] data_q;
  logic       carry_q, zero_q, err_q;
  logic       accept, div_zero, capture;

  assign bus.cmd_ready = (state_q == IDLE) && !rst;
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign div_zero      = (bus.cmd_op == OP_DIV) && (bus.cmd_b == '0);
  assign capture       = (state_q == EXEC) && (cnt_q == '0);

  assign bus.A         = a_q;
  assign bus.B         = b_q;
  assign bus.alu_sel   = sel_q;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = data_q;
  assign bus.rsp_carry = carry_q;
  assign bus.rsp_zero  = zero_q;
  assign bus.rsp_err   = err_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = div_zero ? RESP : EXEC;
      EXEC:    if (cnt_q == '0) state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q   <= bus.cmd_a;
        b_q   <= bus.cmd_b;
        sel_q <= bus.cmd_op;
        cnt_q <= CNT_INIT;
        // Divide-by-zero never reaches the ALU: the error response is built here.
        if (div_zero) begin
          data_q  <= 8'hFF;
          carry_q <= 1'b0;
          zero_q  <= 1'b0;
          err_q   <= 1'b1;
        end
      end else if (capture) begin
        data_q  <= bus.alu_out;
        carry_q <= (sel_q == OP_ADD) ? bus.c_out : 1'b0;
        zero_q  <= (bus.alu_out == '0);
        err_q   <= 1'b0;
      end else if (state_q == EXEC) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench: three alu_ctrl instances (EXEC_CYCLES 1, 3, 4) share one
// stimulus bus, steered by sel; a behavioural ALU stub answers each instance.
module tb_alu_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [3:0] cmd_op = '0;
  logic [7:0] cmd_a = '0;
  logic [7:0] cmd_b = '0;
  logic       rsp_ready = 1'b0;
  int         sel = 0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // External ALU stub; sub/default/div-by-zero raise c_out so carry gating is exercised.
  function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [3:0] op);
    case (op)
      4'd0:    return {1'b0, a} + {1'b0, b};
      4'd1:    return {1'b0, a} - {1'b0, b};
      4'd2:    return {1'b0, a & b};
      4'd3:    return (b == 8'd0) ? 9'h100 : {1'b0, a / b};
      4'd4:    return {1'b0, a | b};
      4'd5:    return {1'b0, a ^ b};
      default: return {1'b1, a};
    endcase
  endfunction

  function automatic int ec_of(input int s);
    return (s == 0) ? 1 : (s == 1) ? 3 : 4;
  endfunction

  alu_ctrl_if if0 ();
  alu_ctrl_if if1 ();
  alu_ctrl_if if2 ();

  assign if0.cmd_valid = cmd_valid && (sel == 0);
  assign if1.cmd_valid = cmd_valid && (sel == 1);
  assign if2.cmd_valid = cmd_valid && (sel == 2);
  assign if0.rsp_ready = rsp_ready && (sel == 0);
  assign if1.rsp_ready = rsp_ready && (sel == 1);
  assign if2.rsp_ready = rsp_ready && (sel == 2);
  assign if0.cmd_op = cmd_op;  assign if0.cmd_a = cmd_a;  assign if0.cmd_b = cmd_b;
  assign if1.cmd_op = cmd_op;  assign if1.cmd_a = cmd_a;  assign if1.cmd_b = cmd_b;
  assign if2.cmd_op = cmd_op;  assign if2.cmd_a = cmd_a;  assign if2.cmd_b = cmd_b;
  assign {if0.c_out, if0.alu_out} = alu_f(if0.A, if0.B, if0.alu_sel);
  assign {if1.c_out, if1.alu_out} = alu_f(if1.A, if1.B, if1.alu_sel);
  assign {if2.c_out, if2.alu_out} = alu_f(if2.A, if2.B, if2.alu_sel);

  alu_ctrl #(.EXEC_CYCLES(1)) u0 (.clk(clk), .rst(rst), .bus(if0));
  alu_ctrl #(.EXEC_CYCLES(3)) u1 (.clk(clk), .rst(rst), .bus(if1));
  alu_ctrl #(.EXEC_CYCLES(4)) u2 (.clk(clk), .rst(rst), .bus(if2));

  logic       m_ready, m_valid, m_carry, m_zero, m_err;
  logic [7:0] m_data, m_a, m_b;
  logic [3:0] m_sel;

  always_comb begin
    m_ready = if0.cmd_ready; m_valid = if0.rsp_valid; m_data = if0.rsp_data;
    m_carry = if0.rsp_carry; m_zero = if0.rsp_zero;   m_err = if0.rsp_err;
    m_a = if0.A; m_b = if0.B; m_sel = if0.alu_sel;
    if (sel == 1) begin
      m_ready = if1.cmd_ready; m_valid = if1.rsp_valid; m_data = if1.rsp_data;
      m_carry = if1.rsp_carry; m_zero = if1.rsp_zero;   m_err = if1.rsp_err;
      m_a = if1.A; m_b = if1.B; m_sel = if1.alu_sel;
    end else if (sel == 2) begin
      m_ready = if2.cmd_ready; m_valid = if2.rsp_valid; m_data = if2.rsp_data;
      m_carry = if2.rsp_carry; m_zero = if2.rsp_zero;   m_err = if2.rsp_err;
      m_a = if2.A; m_b = if2.B; m_sel = if2.alu_sel;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (dut %0d): got %0h expected %0h at %0t", name, sel, act, exp, $time);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_A"}, 32'(m_a), 32'd0);
    check({tag, "_B"}, 32'(m_b), 32'd0);
    check({tag, "_sel"}, 32'(m_sel), 32'd0);
    check({tag, "_data"}, 32'(m_data), 32'd0);
    check({tag, "_flags"}, 32'({m_valid, m_carry, m_zero, m_err}), 32'd0);
  endtask

  // One full command: accept, wait for the response, optional backpressure, handshake.
  task automatic run_txn(input int s, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] ed, input logic ecy,
                         input logic ez, input logic ee, input int hold);
    int lat;
    int exp_lat;
    sel = s;
    @(negedge clk);
    check("cmd_ready_idle", 32'(m_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_a = ~a; cmd_b = ~b; cmd_op = ~op;
    check("operands", 32'({m_a, m_b, m_sel}), 32'({a, b, op}));
    lat = 0;
    while (!m_valid && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    exp_lat = (op == 4'd3 && b == 8'd0) ? 0 : ec_of(s);
    check("latency", 32'(lat), 32'(exp_lat));
    check("rsp_data", 32'(m_data), 32'(ed));
    check("rsp_flags", 32'({m_carry, m_zero, m_err}), 32'({ecy, ez, ee}));
    for (int i = 0; i < hold; i++) begin
      rsp_ready = 1'b0;
      if (i == 1) begin
        cmd_valid = 1'b1; cmd_op = 4'd0; cmd_a = a + 8'd1; cmd_b = b + 8'd1;
      end
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("hold_valid_ready", 32'({m_valid, m_ready}), 32'b10);
      check("hold_rsp", 32'({m_data, m_carry, m_zero, m_err}), 32'({ed, ecy, ez, ee}));
    end
    if (hold > 1) check("held_operands", 32'({m_a, m_b, m_sel}), 32'({a, b, op}));
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_hs_valid_ready", 32'({m_valid, m_ready}), 32'b01);
    check("post_hs_data", 32'(m_data), 32'(ed));
  endtask

  typedef struct {
    int         s;
    logic [3:0] op;
    logic [7:0] a, b, d;
    logic       c, z, e;
    int         hold;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 4'h0, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1'b0, 1};
    tbl[1] = '{1, 4'h1, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1, 1'b0, 0};
    tbl[2] = '{0, 4'h3, 8'h40, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 2};
    tbl[3] = '{1, 4'h5, 8'h0F, 8'h55, 8'h5A, 1'b0, 1'b0, 1'b0, 5};
    tbl[4] = '{2, 4'h2, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b0, 0};
    tbl[5] = '{0, 4'h0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 0};
    tbl[6] = '{1, 4'h3, 8'h64, 8'h05, 8'h14, 1'b0, 1'b0, 1'b0, 1};
    tbl[7] = '{2, 4'h4, 8'h12, 8'h21, 8'h33, 1'b0, 1'b0, 1'b0, 3};
    tbl[8] = '{0, 4'h1, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 1'b0, 0};
    tbl[9] = '{2, 4'h9, 8'h00, 8'h77, 8'h00, 1'b0, 1'b1, 1'b0, 0};

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check("rst_cmd_ready", 32'(m_ready), 32'd0);
      check_cleared("rst");
    end
    rst = 1'b0;
    sel = 0;
    #1;
    check("rst_release_ready", 32'(m_ready), 32'd1);

    for (int i = 0; i < 10; i++)
      run_txn(tbl[i].s, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].d,
              tbl[i].c, tbl[i].z, tbl[i].e, tbl[i].hold);

    // Randomized commands against the arithmetic reference
    for (int i = 0; i < 60; i++) begin
      int         s;
      logic [3:0] op;
      logic [7:0] a, b, ed;
      logic       ecy, ez, ee;
      logic [8:0] sum;
      s  = int'($urandom_range(2, 0));
      op = 4'($urandom_range(7, 0));
      a  = 8'($urandom);
      b  = ($urandom_range(3, 0) == 0) ? 8'd0 : 8'($urandom);
      ecy = 1'b0; ee = 1'b0;
      case (op)
        4'd0: begin sum = {1'b0, a} + {1'b0, b}; ed = sum[7:0]; ecy = sum[8]; end
        4'd1: ed = a - b;
        4'd2: ed = a & b;
        4'd3: if (b == 8'd0) begin ed = 8'hFF; ee = 1'b1; end else ed = a / b;
        4'd4: ed = a | b;
        4'd5: ed = a ^ b;
        default: ed = a;
      endcase
      ez = (ed == 8'd0) && !ee;
      run_txn(s, op, a, b, ed, ecy, ez, ee, int'($urandom_range(3, 0)));
    end

    // Reset in the 2nd EXEC cycle, EXEC_CYCLES = 4
    run_txn(2, 4'h4, 8'h12, 8'h21, 8'h33, 1'b0, 1'b0, 1'b0, 0);
    sel = 2;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'h0; cmd_a = 8'h01; cmd_b = 8'h02;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("exec_mid_valid", 32'(m_valid), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("exec_rst_ready", 32'(m_ready), 32'd0);
    check_cleared("exec_rst");
    rst = 1'b0;
    #1;
    check("exec_rst_release_ready", 32'(m_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("exec_rst_no_rsp", 32'({m_valid, m_ready}), 32'b01);
    end

    // Reset while a response is pending, EXEC_CYCLES = 1
    sel = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'h0; cmd_a = 8'h01; cmd_b = 8'h01;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("resp_pending", 32'({m_valid, m_data}), 32'({1'b1, 8'h02}));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_cleared("resp_rst");
    @(posedge clk);
    @(negedge clk);
    check("resp_rst_idle", 32'({m_valid, m_ready}), 32'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
